// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: AXI4-Lite-style instruction read channel plus the
// {inst, pc} valid/ready channel towards decode.
interface ifu_fetch_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] pc_out;
    logic            fetch_err;
    logic [XLEN-1:0] inst_count;

    modport master (
        output araddr, arvalid, rready,
        output out_valid, inst_out, pc_out, fetch_err, inst_count,
        input  arready, rdata, rresp, rvalid, out_ready
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  out_valid, inst_out, pc_out, fetch_err, inst_count,
        output arready, rdata, rresp, rvalid, out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding single-beat read at a time, result
// held for decode until accepted; a jump redirects and discards in-flight data.
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_pc,
    ifu_fetch_if.master     bus
);

    typedef enum logic [1:0] {
        S_AR  = 2'b00,
        S_R   = 2'b01,
        S_OUT = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_seq_s;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] inst_out_q, inst_out_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            fetch_err_q, fetch_err_d;
    logic [XLEN-1:0] inst_count_q, inst_count_d;
    logic [XLEN-1:0] jump_tgt_s;

    assign jump_tgt_s = jump_pc & 32'hFFFF_FFFC;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_AR;
            pc_q         <= RESET_PC;
            araddr_q     <= RESET_PC;
            drop_q       <= 1'b0;
            inst_out_q   <= 32'd0;
            pc_out_q     <= 32'd0;
            fetch_err_q  <= 1'b0;
            inst_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            drop_q       <= drop_d;
            inst_out_q   <= inst_out_d;
            pc_out_q     <= pc_out_d;
            fetch_err_q  <= fetch_err_d;
            inst_count_q <= inst_count_d;
        end
    end

    // Next-state, PC and output-latch logic; jump overrides the sequential PC
    always_comb begin
        state_d      = state_q;
        pc_seq_s     = pc_q;
        drop_d       = drop_q;
        inst_out_d   = inst_out_q;
        pc_out_d     = pc_out_q;
        fetch_err_d  = fetch_err_q;
        inst_count_d = inst_count_q;
        case (state_q)
            S_AR: begin
                if (bus.arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
                // the address already on the bus is still issued; its beat gets discarded
                if (jump) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            S_R: begin
                if (bus.rvalid) begin
                    if (drop_q || jump) begin
                        drop_d  = 1'b0;
                        state_d = S_AR;
                    end else begin
                        inst_out_d  = bus.rdata;
                        pc_out_d    = pc_q;
                        fetch_err_d = (bus.rresp != 2'b00);
                        state_d     = S_OUT;
                    end
                end else begin
                    if (jump) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    pc_seq_s     = pc_q + 32'd4;
                    inst_count_d = inst_count_q + 32'd1;
                    state_d      = S_AR;
                end else if (jump) begin
                    state_d = S_AR;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_AR;
                drop_d  = 1'b0;
            end
        endcase
        if (jump) begin
            pc_d = jump_tgt_s;
        end else begin
            pc_d = pc_seq_s;
        end
        // araddr is frozen while arvalid is up so a redirect cannot disturb a pending AR
        if (state_q == S_AR) begin
            araddr_d = araddr_q;
        end else begin
            araddr_d = pc_d;
        end
    end

    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = (state_q == S_AR);
    assign bus.rready     = (state_q == S_R);
    assign bus.out_valid  = (state_q == S_OUT);
    assign bus.inst_out   = inst_out_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.inst_count = inst_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: table-driven fetches through a memory
// responder and a delivery scoreboard, then directed redirect/reset sequences.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clock;
    logic        reset;
    logic        jump;
    logic [31:0] jump_pc;

    ifu_fetch_if #(.XLEN(32)) bus ();

    ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clock   (clock),
        .reset   (reset),
        .jump    (jump),
        .jump_pc (jump_pc),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } sb_t;

    typedef struct {
        int          stall;
        int          hold;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;

    // memory responder state
    bit          pend;
    int          stall_cnt;
    int          r_wait;
    bit          stray;
    logic [31:0] cur_data;
    logic [1:0]  cur_resp;
    logic [31:0] cur_exp_inst;
    logic        cur_exp_err;

    // reference model state
    int          phase;      // 0: address phase, 1: awaiting data, 2: presenting to decode
    bit          fetch_drop;
    logic [31:0] model_pc;
    logic [31:0] exp_ar;
    logic [31:0] fetch_addr;
    logic [31:0] exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive memory inputs, check outputs, advance the model, then one clock.
    task automatic step();
        logic [31:0] tgt;
        logic [2:0]  exp_hs;
        bit          ar_fire, r_fire, o_fire;
        sb_t         e;
        if (stray) begin
            bus.rvalid = 1'b1;
            stray      = 1'b0;
        end else if (pend && r_wait == 0) begin
            bus.rvalid = 1'b1;
        end else begin
            bus.rvalid = 1'b0;
            if (pend && r_wait > 0) r_wait--;
        end
        bus.rdata   = cur_data;
        bus.rresp   = cur_resp;
        bus.arready = (stall_cnt == 0);
        if (bus.arvalid === 1'b1 && stall_cnt != 0) stall_cnt--;
        ar_fire = (bus.arvalid === 1'b1) && bus.arready;
        r_fire  = bus.rvalid && (bus.rready === 1'b1);
        o_fire  = (bus.out_valid === 1'b1) && bus.out_ready;
        tgt     = {jump_pc[31:2], 2'b00};
        if (reset) begin
            pend = 1'b0; stall_cnt = 0; r_wait = 0;
            phase = 0; fetch_drop = 1'b0; model_pc = RESET_PC; exp_ar = RESET_PC;
            exp_count = 32'd0; sb.delete();
        end else begin
            exp_hs = (phase == 0) ? 3'b100 : (phase == 1) ? 3'b010 : 3'b001;
            chk("handshake_state", {29'd0, bus.arvalid, bus.rready, bus.out_valid}, {29'd0, exp_hs});
            chk("inst_count", bus.inst_count, exp_count);
            if (phase == 0) chk("araddr", bus.araddr, exp_ar);
            if (phase == 2) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got out_valid with 0 entries expected 1");
                end else begin
                    e = sb[0];
                    chk("pc_out", bus.pc_out, e.pc);
                    chk("inst_out", bus.inst_out, e.inst);
                    chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, e.err});
                end
            end
            if (ar_fire) pend = 1'b1;
            if (r_fire) pend = 1'b0;
            case (phase)
                0: begin
                    if (jump) begin fetch_drop = 1'b1; model_pc = tgt; end
                    if (ar_fire) begin fetch_addr = exp_ar; phase = 1; end
                end
                1: begin
                    if (r_fire) begin
                        if (fetch_drop || jump) begin
                            if (jump) model_pc = tgt;
                            fetch_drop = 1'b0; exp_ar = model_pc; phase = 0;
                        end else begin
                            e.pc = fetch_addr; e.inst = cur_exp_inst; e.err = cur_exp_err;
                            sb.push_back(e);
                            phase = 2;
                        end
                    end else if (jump) begin
                        fetch_drop = 1'b1; model_pc = tgt;
                    end
                end
                default: begin
                    if (o_fire) begin
                        if (sb.size() > 0) sb.delete(0);
                        exp_count = exp_count + 32'd1;
                        model_pc = jump ? tgt : model_pc + 32'd4;
                        exp_ar = model_pc; phase = 0;
                    end else if (jump) begin
                        if (sb.size() > 0) sb.delete(0);
                        model_pc = tgt; exp_ar = tgt; phase = 0;
                    end
                end
            endcase
        end
        @(posedge clock);
        @(negedge clock);
        jump = 1'b0;
    endtask

    // Run until n instructions are handed to decode, holding out_ready low
    // for 'hold' cycles of each presentation; a blown budget is a failure.
    task automatic deliver(input int n, input int hold, input int bound, output int cycles);
        int got = 0;
        int h   = hold;
        cycles = 0;
        while (got < n && cycles < bound) begin
            if (bus.out_valid === 1'b1) begin
                if (h > 0) begin
                    bus.out_ready = 1'b0; h--;
                end else begin
                    bus.out_ready = 1'b1; got++; h = hold;
                end
            end else begin
                bus.out_ready = 1'b0;
            end
            step();
            cycles++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL deliver_timeout: got %0d deliveries expected %0d", got, n);
        end
    endtask

    task automatic set_mem(input logic [31:0] d, input logic [1:0] r);
        cur_data = d; cur_resp = r; cur_exp_inst = d; cur_exp_err = (r != 2'b00);
    endtask

    initial begin
        int cy;
        vecs[0] = '{0, 0, 32'h0000_0013, 2'b00, 32'h8000_0000, 32'h0000_0013, 1'b0};
        vecs[1] = '{0, 5, 32'h0050_0093, 2'b00, 32'h8000_0004, 32'h0050_0093, 1'b0};
        vecs[2] = '{3, 0, 32'hDEAD_BEEF, 2'b10, 32'h8000_0008, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1, 1, 32'h1234_5678, 2'b00, 32'h8000_000C, 32'h1234_5678, 1'b0};
        vecs[4] = '{2, 2, 32'hCAFE_F00D, 2'b11, 32'h8000_0010, 32'hCAFE_F00D, 1'b1};

        reset = 1'b1; jump = 1'b0; jump_pc = 32'd0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00;
        bus.out_ready = 1'b0;
        pend = 1'b0; stall_cnt = 0; r_wait = 0; stray = 1'b0;
        set_mem(32'd0, 2'b00);
        repeat (3) step();
        reset = 1'b0;

        chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("rst_araddr", bus.araddr, RESET_PC);
        chk("rst_rready", {31'd0, bus.rready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_inst_out", bus.inst_out, 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'd0);
        chk("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
        chk("rst_inst_count", bus.inst_count, 32'd0);

        // table: back-to-back fetches with AR stalls, decode back-pressure, error responses
        for (int i = 0; i < 5; i++) begin
            set_mem(vecs[i].data, vecs[i].resp);
            cur_exp_inst = vecs[i].exp_inst;
            cur_exp_err  = vecs[i].exp_err;
            stall_cnt    = vecs[i].stall;
            deliver(1, vecs[i].hold, 40, cy);
            chk("vec_latency", cy, vecs[i].stall + vecs[i].hold + 3);
            chk("vec_pc", bus.pc_out, vecs[i].exp_pc);
            chk("vec_inst", bus.inst_out, vecs[i].exp_inst);
            chk("vec_err", {31'd0, bus.fetch_err}, {31'd0, vecs[i].exp_err});
        end
        chk("table_count", bus.inst_count, 32'd5);

        // jump while the AR is stalled: old address still issued and dropped
        set_mem(32'h0000_0297, 2'b00);
        stall_cnt = 4;
        step();
        jump = 1'b1; jump_pc = 32'h8000_0100;
        step();
        deliver(1, 0, 30, cy);
        chk("redirect_pc", bus.pc_out, 32'h8000_0100);

        // jump and out_ready together in S_OUT: jump target wins, count still bumps
        set_mem(32'h0000_0513, 2'b00);
        for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) step();
        chk("reach_out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1; jump = 1'b1; jump_pc = 32'h8000_0203;
        step();
        bus.out_ready = 1'b0;
        chk("jump_wins_araddr", bus.araddr, 32'h8000_0200);
        chk("jump_wins_count", bus.inst_count, 32'd7);

        // jump coinciding with arready, landing on the top word: PC wraps to 0
        set_mem(32'h0000_0073, 2'b00);
        jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
        step();
        deliver(1, 0, 30, cy);
        chk("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap_araddr", bus.araddr, 32'h0000_0000);

        // two jumps while waiting for data: one beat dropped, last target fetched
        set_mem(32'h0000_1117, 2'b00);
        r_wait = 3;
        step();
        jump = 1'b1; jump_pc = 32'h0000_1000;
        step();
        jump = 1'b1; jump_pc = 32'h0000_2000;
        step();
        deliver(1, 0, 30, cy);
        chk("double_jump_pc", bus.pc_out, 32'h0000_2000);

        // jump in the same cycle as the data beat
        set_mem(32'h0000_2223, 2'b10);
        step();
        jump = 1'b1; jump_pc = 32'h0000_3000;
        step();
        deliver(1, 0, 30, cy);
        chk("jump_with_rvalid_pc", bus.pc_out, 32'h0000_3000);
        chk("jump_with_rvalid_count", bus.inst_count, 32'd10);

        // reset while waiting for data, then a stray beat after release
        r_wait = 5;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("midrst_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("midrst_araddr", bus.araddr, RESET_PC);
        chk("midrst_rready", {31'd0, bus.rready}, 32'd0);
        chk("midrst_inst_count", bus.inst_count, 32'd0);
        chk("midrst_pc_out", bus.pc_out, 32'd0);
        set_mem(32'h0000_0013, 2'b00);
        stall_cnt = 1;
        stray = 1'b1;
        step();
        deliver(1, 0, 30, cy);
        chk("midrst_refetch_pc", bus.pc_out, RESET_PC);
        chk("midrst_refetch_count", bus.inst_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
